// File: rtl/mem_pkg.sv
// Shared address map, MemToReg encodings and EX/MEM register layout for the
// memory stage and its peripheral block.
package mem_pkg;

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
    localparam int          RAM_WORDS = 256;

    typedef enum logic [1:0] {
        M2R_ALU  = 2'b00,
        M2R_LOAD = 2'b01,
        M2R_PC4  = 2'b10,
        M2R_NONE = 2'b11
    } memToReg_e;

    typedef struct packed {
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic [1:0]  memToReg;
        logic [4:0]  writeReg;
        logic [31:0] aluOut;
        logic [31:0] writeData;
        logic [31:0] pc4;
    } exMem_t;

    // RAM occupies the first 1 KiB; anything above is not RAM.
    function automatic logic isRamAddr(input logic [31:0] addr);
        return addr[31:10] == 22'd0;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Execute-to-memory bundle plus the MEM/WB results fed back for forwarding.
// Handshake: none; the stage accepts one EX bundle on every rising clk edge, no stall or backpressure.
interface mem_if;
    logic [63:0] EX_MEM;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_RegWrite;
    logic [1:0]  EX_MemToReg;
    logic [4:0]  EX_WriteRegister;
    logic [31:0] EX_PC4;

    logic        MEM_RegWrite;
    logic [4:0]  MEM_WriteRegister;
    logic [31:0] MEM_RegWriteData;
    logic        MEM_MemRead;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteRegister;
    logic [31:0] WB_RegWriteData;

    modport master (
        output EX_MEM, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg,
               EX_WriteRegister, EX_PC4,
        input  MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData, MEM_MemRead,
               WB_RegWrite, WB_WriteRegister, WB_RegWriteData
    );

    modport slave (
        input  EX_MEM, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg,
               EX_WriteRegister, EX_PC4,
        output MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData, MEM_MemRead,
               WB_RegWrite, WB_WriteRegister, WB_RegWriteData
    );
endinterface

// File: rtl/periph_timer.sv
// Memory-mapped timer (TH/TL/TCON) and LED register; reads are combinational,
// writes land on the clock edge that ends the MEM cycle.
module periph_timer
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wrEn,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    output logic [7:0]  led,
    output logic        irq
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  ledReg;

    // Software writes come after the timer update so they take priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            th     <= '0;
            tl     <= '0;
            tcon   <= '0;
            ledReg <= '0;
        end else begin
            if (tcon[0]) begin
                if (tl == 32'hFFFF_FFFF) begin
                    tl <= th;
                    if (tcon[1]) tcon[2] <= 1'b1;
                end else begin
                    tl <= tl + 32'd1;
                end
            end
            if (wrEn) begin
                case (addr)
                    ADDR_TH:   th     <= wrData;
                    ADDR_TL:   tl     <= wrData;
                    ADDR_TCON: tcon   <= wrData[2:0];
                    ADDR_LED:  ledReg <= wrData[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdData = '0;
        case (addr)
            ADDR_TH:   rdData = th;
            ADDR_TL:   rdData = tl;
            ADDR_TCON: rdData = {29'd0, tcon};
            ADDR_LED:  rdData = {24'd0, ledReg};
            default:   rdData = '0;
        endcase
    end

    assign led = ledReg;
    assign irq = tcon[2];

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, 256-word data RAM, timer/LED
// peripherals, writeback mux and MEM/WB register.
module mem_stage
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_if.slave       bus,
    output logic [7:0] led,
    output logic       irq
);

    exMem_t      exMem;
    logic [31:0] wordAddr;
    logic        ramHit;
    logic [7:0]  ramIdx;
    logic [31:0] ramRd;
    logic [31:0] periphRd;
    logic [31:0] readData;
    logic [31:0] regWriteData;
    logic [31:0] ram [0:RAM_WORDS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            exMem <= '0;
        end else begin
            exMem.memRead   <= bus.EX_MemRead;
            exMem.memWrite  <= bus.EX_MemWrite;
            exMem.regWrite  <= bus.EX_RegWrite;
            exMem.memToReg  <= bus.EX_MemToReg;
            exMem.writeReg  <= bus.EX_WriteRegister;
            exMem.aluOut    <= bus.EX_MEM[63:32];
            exMem.writeData <= bus.EX_MEM[31:0];
            exMem.pc4       <= bus.EX_PC4;
        end
    end

    // Word access only: the byte offset is dropped before decoding.
    assign wordAddr = exMem.aluOut & ~32'h3;
    assign ramHit   = isRamAddr(wordAddr);
    assign ramIdx   = wordAddr[9:2];
    assign ramRd    = ram[ramIdx];

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (exMem.memWrite && ramHit) ram[ramIdx] <= exMem.writeData;
    end

    periph_timer u_periph (
        .clk    (clk),
        .rst    (rst),
        .addr   (wordAddr),
        .wrEn   (exMem.memWrite),
        .wrData (exMem.writeData),
        .rdData (periphRd),
        .led    (led),
        .irq    (irq)
    );

    assign readData = ramHit ? ramRd : periphRd;

    always_comb begin
        regWriteData = '0;
        case (exMem.memToReg)
            M2R_ALU:  regWriteData = exMem.aluOut;
            M2R_LOAD: regWriteData = readData;
            M2R_PC4:  regWriteData = exMem.pc4;
            default:  regWriteData = '0;
        endcase
    end

    assign bus.MEM_RegWrite      = exMem.regWrite;
    assign bus.MEM_WriteRegister = exMem.writeReg;
    assign bus.MEM_RegWriteData  = regWriteData;
    assign bus.MEM_MemRead       = exMem.memRead;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.WB_RegWrite      <= 1'b0;
            bus.WB_WriteRegister <= '0;
            bus.WB_RegWriteData  <= '0;
        end else begin
            bus.WB_RegWrite      <= exMem.regWrite;
            bus.WB_WriteRegister <= exMem.writeReg;
            bus.WB_RegWriteData  <= regWriteData;
        end
    end

endmodule
